// File: rtl/gnl_vr_fifo.sv
// gnl_vr_fifo: valid/ready FIFO on load-enable DFFs, registered 1-cycle latency.
// Define GNL_VR_FIFO_BYPASS_EN for a 0-cycle combinational bypass while empty.
module gnl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) if (lden) qout <= dnxt;
endmodule

module gnl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) qout <= '0;
    else if (lden) qout <= dnxt;
endmodule

module gnl_vr_fifo #(
  parameter int DW = 32,
  parameter int DP = 2,
  localparam int AW = (DP > 1) ? $clog2(DP) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [AW:0]   cnt
);
  logic [AW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [AW:0]   cnt_nxt;
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] head;
  logic          full, empty, byp, push, pop;
  assign full  = cnt == (AW+1)'(DP);
  assign empty = cnt == '0;
  assign i_rdy = !full;
`ifdef GNL_VR_FIFO_BYPASS_EN
  // An empty FIFO hands the producer beat straight to a ready consumer.
  assign byp   = empty & i_vld & o_rdy;
  assign o_vld = !empty | i_vld;
  assign o_dat = empty ? i_dat : head;
`else
  assign byp   = 1'b0;
  assign o_vld = !empty;
  assign o_dat = head;
`endif
  // Flush discards any handshake in its cycle, so storage is never written then.
  assign push = i_vld & i_rdy & !byp & !flush;
  assign pop  = !empty & o_rdy & !flush;
  assign wptr_nxt = (flush || wptr == AW'(DP-1)) ? '0 : wptr + 1'b1;
  assign rptr_nxt = (flush || rptr == AW'(DP-1)) ? '0 : rptr + 1'b1;
  assign cnt_nxt  = flush ? '0 : push ? cnt + 1'b1 : cnt - 1'b1;
  always_comb begin
    head = mem[0];
    for (int k = 1; k < DP; k++) head = (rptr == AW'(k)) ? mem[k] : head;
  end
  gnl_dfflr #(.DW(AW)) u_wptr (
    .clk(clk), .rst_n(rst_n), .lden(push | flush), .dnxt(wptr_nxt), .qout(wptr)
  );
  gnl_dfflr #(.DW(AW)) u_rptr (
    .clk(clk), .rst_n(rst_n), .lden(pop | flush), .dnxt(rptr_nxt), .qout(rptr)
  );
  gnl_dfflr #(.DW(AW+1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .lden((push ^ pop) | flush), .dnxt(cnt_nxt), .qout(cnt)
  );
  for (genvar i = 0; i < DP; i++) begin : g_ent
    gnl_dffl #(.DW(DW)) u_ent (
      .clk(clk), .lden(push && wptr == AW'(i)), .dnxt(i_dat), .qout(mem[i])
    );
  end
endmodule

// File: tb/tb_gnl_vr_fifo.sv
// tb_gnl_vr_fifo: DP=2 and DP=3 FIFOs on shared stimulus, checked against queue models.
module tb_gnl_vr_fifo;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, i_vld = 1'b0, o_rdy = 1'b0;
  logic [31:0] i_dat = '0;
  logic        a_rdy, a_vld, b_rdy, b_vld;
  logic [31:0] a_dat, b_dat;
  logic [1:0]  a_cnt;
  logic [2:0]  b_cnt;
  logic [31:0] qa[$], qb[$];
  int          pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  gnl_vr_fifo #(.DW(32), .DP(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(a_rdy), .i_dat(i_dat),
    .o_vld(a_vld), .o_rdy(o_rdy), .o_dat(a_dat), .cnt(a_cnt)
  );
  gnl_vr_fifo #(.DW(32), .DP(3)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(b_rdy), .i_dat(i_dat),
    .o_vld(b_vld), .o_rdy(o_rdy), .o_dat(b_dat), .cnt(b_cnt)
  );
  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask
  // Model: the queue holds what the consumer has yet to see, oldest first.
  task automatic step(input int id);
    logic [31:0] q[$];
    logic [31:0] od;
    logic ov, ir, bp, ev, rdy;
    int d, cn;
    if (id == 0) begin
      q = qa; d = 2; ov = a_vld; ir = a_rdy; od = a_dat; cn = int'(a_cnt);
    end else begin
      q = qb; d = 3; ov = b_vld; ir = b_rdy; od = b_dat; cn = int'(b_cnt);
    end
    bp = 1'b0;
`ifdef GNL_VR_FIFO_BYPASS_EN
    bp = q.size() == 0 && i_vld;
`endif
    ev  = q.size() > 0 || bp;
    rdy = q.size() < d;
    chk($sformatf("cnt[%0d]", id), cn, q.size());
    chk($sformatf("o_vld[%0d]", id), int'(ov), int'(ev));
    chk($sformatf("i_rdy[%0d]", id), int'(ir), int'(rdy));
    if (ev) chk($sformatf("o_dat[%0d]", id), od, bp ? i_dat : q[0]);
    if (flush) q.delete();
    else if (!(bp && o_rdy)) begin
      if (ev && o_rdy) void'(q.pop_front());
      if (i_vld && rdy) q.push_back(i_dat);
    end
    if (id == 0) qa = q;
    else qb = q;
  endtask
  always @(negedge clk) if (rst_n) begin
    step(0);
    step(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cnt", int'(a_cnt), 0);
    chk("rst_vld", int'(a_vld), 0);
    chk("rst_rdy", int'(a_rdy), 1);
    cyc();
    rst_n = 1'b1;
    i_vld = 1'b1; i_dat = 32'h11; o_rdy = 1'b0;
    cyc();
    i_dat = 32'h22;
    cyc();
    i_dat = 32'h99;
    cyc();
    chk("full_cnt", int'(a_cnt), 2);
    chk("full_rdy", int'(a_rdy), 0);
    chk("full_vld", int'(a_vld), 1);
    chk("full_dat", a_dat, 32'h11);
    chk("b_cnt3", int'(b_cnt), 3);
    i_vld = 1'b0; o_rdy = 1'b1;
    cyc();
    chk("pop1_cnt", int'(a_cnt), 1);
    chk("pop1_dat", a_dat, 32'h22);
    chk("pop1_rdy", int'(a_rdy), 1);
    cyc();
    chk("pop2_vld", int'(a_vld), 0);
    chk("pop2_cnt", int'(a_cnt), 0);
    o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'h33;
    cyc();
    o_rdy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      i_dat = 32'h33 + 32'h11 * k;
      cyc();
      chk($sformatf("stream_dat%0d", k), a_dat, 32'h33 + 32'h11 * k);
      chk($sformatf("stream_cnt%0d", k), int'(a_cnt), 1);
    end
    o_rdy = 1'b0; i_dat = 32'hAA;
    cyc();
    chk("pre_flush_cnt", int'(a_cnt), 2);
    flush = 1'b1; i_dat = 32'hBB; o_rdy = 1'b1;
    cyc();
    flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
    chk("flush_cnt", int'(a_cnt), 0);
    chk("flush_vld", int'(a_vld), 0);
    chk("flush_rdy", int'(a_rdy), 1);
    i_vld = 1'b1; i_dat = 32'hCC;
    cyc();
    chk("post_flush_dat", a_dat, 32'hCC);
    chk("post_flush_cnt", int'(a_cnt), 1);
    i_dat = 32'hDD;
    cyc();
    i_vld = 1'b0;
    chk("pre_rst_cnt", int'(a_cnt), 2);
    rst_n = 1'b0;
    #2;
    chk("arst_cnt", int'(a_cnt), 0);
    chk("arst_vld", int'(a_vld), 0);
    chk("arst_rdy", int'(a_rdy), 1);
    chk("arst_bcnt", int'(b_cnt), 0);
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
    i_vld = 1'b1; i_dat = 32'h55;
    cyc();
    i_vld = 1'b0;
    chk("post_rst_dat", a_dat, 32'h55);
    o_rdy = 1'b1;
    cyc();
    o_rdy = 1'b0;
`ifdef GNL_VR_FIFO_BYPASS_EN
    i_vld = 1'b1; i_dat = 32'h66; o_rdy = 1'b1;
    #1;
    chk("byp_vld", int'(a_vld), 1);
    chk("byp_dat", a_dat, 32'h66);
    chk("byp_cnt", int'(a_cnt), 0);
    cyc();
    chk("byp_cnt_after", int'(a_cnt), 0);
    o_rdy = 1'b0;
    cyc();
    i_vld = 1'b0;
    chk("byp_push_cnt", int'(a_cnt), 1);
    o_rdy = 1'b1;
    cyc();
    o_rdy = 1'b0;
`endif
    for (int n = 0; n < 3000; n++) begin
      i_vld = 1'($urandom_range(0, 1));
      o_rdy = ($urandom_range(0, 3) != 0) ^ (n[9] & ($urandom_range(0, 1) == 1));
      flush = $urandom_range(0, 31) == 0;
      i_dat = $urandom;
      cyc();
    end
    i_vld = 1'b0; flush = 1'b0; o_rdy = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
